// File: rtl/hdmi_i2c_arbiter.sv
// Round-robin arbiter that shares one HDMI I2C write engine between the
// configuration sequencer (port 0) and the runtime register port (port 1).
module hdmi_i2c_arbiter #(
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 4095,
  parameter int GAP_CYC     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [23:0] req_data0,
  input  logic [23:0] req_data1,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic        rsp_err,
  output logic [23:0] eng_data,
  output logic        eng_start,
  input  logic        eng_done,
  input  logic        eng_ack_err,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    BACKOFF = 3'd3,
    RESP    = 3'd4,
    GAP     = 3'd5
  } state_t;

  state_t          state_r;
  logic            last_grant_r;
  logic            owner_r;
  logic [RW-1:0]   retry_r;
  logic [TW-1:0]   tmo_r;
  logic [GW-1:0]   gap_r;
  logic [23:0]     eng_data_r;
  logic            eng_start_r;
  logic [1:0]      rsp_valid_r;
  logic            rsp_err_r;
  logic            busy_r;
  logic [7:0]      err_count_r;
  logic            grant_s;
  logic            grant_vld_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) return v;
    else return v + 8'd1;
  endfunction

  // Idle-state grant decision; reset is folded in so req_ready stays low during reset.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_s     = 1'b0;
    if (reset && (state_r == IDLE)) begin
      case (req_valid)
        2'b01:   begin grant_vld_s = 1'b1; grant_s = 1'b0;          end
        2'b10:   begin grant_vld_s = 1'b1; grant_s = 1'b1;          end
        2'b11:   begin grant_vld_s = 1'b1; grant_s = ~last_grant_r; end
        default: begin grant_vld_s = 1'b0; grant_s = 1'b0;          end
      endcase
    end else begin
      grant_vld_s = 1'b0;
      grant_s     = 1'b0;
    end
  end

  assign req_ready = grant_vld_s ? (grant_s ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign eng_data  = eng_data_r;
  assign eng_start = eng_start_r;
  assign busy      = busy_r;
  assign err_count = err_count_r;

  // Transfer sequencer: strobes are registered on the edge entering their state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      retry_r      <= '0;
      tmo_r        <= '0;
      gap_r        <= '0;
      eng_data_r   <= 24'h000000;
      eng_start_r  <= 1'b0;
      rsp_valid_r  <= 2'b00;
      rsp_err_r    <= 1'b0;
      busy_r       <= 1'b0;
      err_count_r  <= 8'h00;
    end else begin
      eng_start_r <= 1'b0;
      rsp_valid_r <= 2'b00;
      rsp_err_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_vld_s) begin
            eng_data_r   <= grant_s ? req_data1 : req_data0;
            owner_r      <= grant_s;
            last_grant_r <= grant_s;
            retry_r      <= '0;
            eng_start_r  <= 1'b1;
            busy_r       <= 1'b1;
            state_r      <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_r   <= '0;
          state_r <= WAIT;
        end
        WAIT: begin
          tmo_r <= tmo_r + TW'(1);
          // A completion on the final timeout cycle still counts as a completion.
          if (eng_done) begin
            if (!eng_ack_err) begin
              rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
              rsp_err_r   <= 1'b0;
              state_r     <= RESP;
            end else if (retry_r < RETRY_MAX) begin
              retry_r <= retry_r + RW'(1);
              gap_r   <= '0;
              state_r <= BACKOFF;
            end else begin
              rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
              rsp_err_r   <= 1'b1;
              state_r     <= RESP;
            end
          end else if (tmo_r == TMO_LAST) begin
            rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
            rsp_err_r   <= 1'b1;
            state_r     <= RESP;
          end
        end
        BACKOFF: begin
          gap_r <= gap_r + GW'(1);
          if (gap_r == GAP_LAST) begin
            eng_start_r <= 1'b1;
            state_r     <= ISSUE;
          end
        end
        RESP: begin
          if (rsp_err_r) err_count_r <= sat_inc(err_count_r);
          gap_r   <= '0;
          state_r <= GAP;
        end
        GAP: begin
          gap_r <= gap_r + GW'(1);
          if (gap_r == GAP_LAST) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_i2c_arbiter.sv
// Self-checking bench for hdmi_i2c_arbiter: directed scenarios plus randomized
// transfers scored against a transaction-level model of arbitration and retry rules.
module tb_hdmi_i2c_arbiter;

  localparam int MR  = 3;
  localparam int TMO = 24;
  localparam int GAP = 4;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [23:0] req_data0, req_data1;
  logic [1:0]  req_ready, rsp_valid;
  logic        rsp_err;
  logic [23:0] eng_data;
  logic        eng_start, eng_done, eng_ack_err, busy;
  logic [7:0]  err_count;

  int checks = 0, failures = 0;
  int cyc = 0, grant_cyc = 0, rsp_cyc = 0;
  int m_err = 0, m_starts = 0, start_cnt = 0, qual_viol = 0;
  logic m_last = 1'b1;

  hdmi_i2c_arbiter #(.MAX_RETRY(MR), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .eng_data(eng_data),
    .eng_start(eng_start), .eng_done(eng_done), .eng_ack_err(eng_ack_err),
    .busy(busy), .err_count(err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (reset === 1'b1 && eng_start === 1'b1) start_cnt++;
    if (rsp_err === 1'b1 && rsp_valid === 2'b00) qual_viol++;
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine side of one granted transfer; returns at the response cycle.
  task automatic serve(input logic owner, input logic [23:0] data, input int n_nack,
                       input int dly, input bit hang);
    int attempts, s_cyc, done_cyc;
    bit exp_err, ok;
    attempts = hang ? 1 : ((n_nack > MR) ? MR + 1 : n_nack + 1);
    exp_err  = hang || (n_nack > MR);
    s_cyc = 0;
    done_cyc = 0;
    for (int a = 0; a < attempts; a++) begin
      ok = 1'b0;
      for (int w = 0; w < 40; w++) begin
        if (eng_start === 1'b1) begin ok = 1'b1; break; end
        step();
      end
      chk("start_seen", ok, 1);
      s_cyc = cyc;
      chk("start_cyc", cyc, (a == 0) ? grant_cyc + 1 : done_cyc + GAP + 1);
      chk("eng_data", eng_data, data);
      m_starts++;
      if (!hang) begin
        for (int d = 0; d < dly; d++) step();
        eng_done = 1'b1;
        eng_ack_err = (a < n_nack);
        done_cyc = cyc;
        step();
        eng_done = 1'b0;
        eng_ack_err = 1'b0;
      end
    end
    ok = 1'b0;
    for (int w = 0; w < TMO + 20; w++) begin
      if (rsp_valid !== 2'b00) begin ok = 1'b1; break; end
      step();
    end
    chk("rsp_seen", ok, 1);
    rsp_cyc = cyc;
    chk("rsp_cyc", cyc, hang ? s_cyc + TMO + 1 : done_cyc + 1);
    chk("rsp_valid", rsp_valid, owner ? 32'd2 : 32'd1);
    chk("rsp_err", rsp_err, exp_err);
    if (exp_err && m_err < 255) m_err++;
  endtask

  task automatic finish_idle(input bit late);
    bit ok;
    if (late) begin
      step();
      eng_done = 1'b1;
      eng_ack_err = 1'b0;
      step();
      eng_done = 1'b0;
    end
    ok = 1'b0;
    for (int w = 0; w < GAP + 20; w++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      step();
    end
    chk("idle_seen", ok, 1);
    chk("idle_cyc", cyc, rsp_cyc + GAP + 1);
    chk("err_count", err_count, m_err);
  endtask

  // One request from an idle arbiter; the losing port (if any) withdraws after the grant.
  task automatic arb(input logic [1:0] v, input logic [23:0] d0, input logic [23:0] d1,
                     input int n_nack, input int dly, input bit hang, input bit late);
    logic exp_g;
    req_data0 = d0;
    req_data1 = d1;
    req_valid = v;
    #1;
    exp_g = (v == 2'b11) ? ~m_last : v[1];
    chk("grant", req_ready, exp_g ? 32'd2 : 32'd1);
    m_last = exp_g;
    grant_cyc = cyc;
    step();
    req_valid = 2'b00;
    serve(exp_g, exp_g ? d1 : d0, n_nack, dly, hang);
    finish_idle(late);
  endtask

  initial begin
    bit ok;
    logic exp_g;
    reset = 1'b0;
    req_valid = 2'b11;
    req_data0 = 24'hABCDEF;
    req_data1 = 24'h123456;
    eng_done = 1'b0;
    eng_ack_err = 1'b0;
    repeat (3) step();
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_data", eng_data, 0);
    req_valid = 2'b00;
    reset = 1'b1;
    m_last = 1'b1;
    step();

    // Both ports continuously valid: grants must alternate starting with port 0.
    req_data0 = 24'h721630;
    req_data1 = 24'h72AF16;
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      ok = 1'b0;
      for (int w = 0; w < GAP + 20; w++) begin
        #1;
        if (req_ready !== 2'b00) begin ok = 1'b1; break; end
        step();
      end
      chk("rr_ready_seen", ok, 1);
      exp_g = ~m_last;
      chk("rr_grant", req_ready, exp_g ? 32'd2 : 32'd1);
      chk("rr_busy", busy, 0);
      if (k > 0) chk("rr_gap", cyc, rsp_cyc + GAP + 1);
      m_last = exp_g;
      grant_cyc = cyc;
      step();
      serve(exp_g, exp_g ? 24'h72AF16 : 24'h721630, 0, $urandom_range(1, 10), 1'b0);
    end
    req_valid = 2'b00;
    finish_idle(1'b0);

    arb(2'b01, 24'h729803, 24'h000000, 0, 20, 1'b0, 1'b0);
    arb(2'b10, 24'h000000, 24'h72A5C3, 3, 2, 1'b0, 1'b0);
    arb(2'b10, 24'h000000, 24'h72A5C4, 4, 2, 1'b0, 1'b0);
    arb(2'b01, 24'h7211EE, 24'h000000, 0, TMO, 1'b0, 1'b0);
    arb(2'b01, 24'h720F0F, 24'h000000, 0, 1, 1'b1, 1'b1);
    arb(2'b01, 24'h72F0F0, 24'h000000, 0, 3, 1'b0, 1'b0);

    repeat (24) begin
      arb(2'($urandom_range(1, 3)), 24'($urandom), 24'($urandom), $urandom_range(0, 4),
          $urandom_range(1, TMO), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    // Reset while waiting on the engine aborts the transfer and clears all state.
    req_data0 = 24'h72BEEF;
    req_valid = 2'b01;
    #1;
    chk("rst_grant", req_ready, 1);
    m_last = 1'b0;
    step();
    req_valid = 2'b00;
    chk("rst_start_seen", eng_start, 1);
    m_starts++;
    repeat (5) step();
    reset = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_rsp", rsp_valid, 0);
    chk("mid_start", eng_start, 0);
    chk("mid_errcnt", err_count, 0);
    chk("mid_data", eng_data, 0);
    step();
    reset = 1'b1;
    m_err = 0;
    m_last = 1'b1;
    step();
    arb(2'b11, 24'h72BEEF, 24'h72CAFE, 0, 5, 1'b0, 1'b0);
    arb(2'b11, 24'h72BEEF, 24'h72CAFE, 1, 5, 1'b0, 1'b0);

    repeat (256) begin
      arb(2'($urandom_range(1, 3)), 24'($urandom), 24'($urandom), MR + 1,
          $urandom_range(1, 3), 1'b0, 1'b0);
    end
    chk("err_sat", err_count, 255);

    repeat (2) step();
    chk("start_total", start_cnt, m_starts);
    chk("err_qualified", qual_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdmi_i2c_arbiter.md
Name: hdmi_i2c_arbiter

Overview:
Shares one HDMI I2C transaction engine (24-bit {dev_addr, reg_addr, data} write) between two requesters. Port 0 is the power-up/hot-plug configuration sequencer; port 1 is the runtime register port (e.g. video-mode reprogramming).
Arbitrates round-robin, sequences each transfer into the engine, retries on NACK, aborts on engine timeout and returns a per-transfer status to the owning requester.
Runs on the I2C control clock domain shared with the engine.

Parameters:
MAX_RETRY, 3, extra attempts after a NACK before reporting error (0 = no retry)
TIMEOUT_CYC, 4095, clk cycles to wait for eng_done before abort (>=1)
GAP_CYC, 4, idle cycles between consecutive engine starts (>=1)

Ports:
clk  in  1  control clock
reset  in  1  asynchronous, active-low
req_valid  in  2  request pending, bit i = port i; held until req_ready[i]
req_data0  in  24  port 0 transfer word, stable while req_valid[0]
req_data1  in  24  port 1 transfer word, stable while req_valid[1]
req_ready  out  2  one-cycle accept strobe; data captured this edge
rsp_valid  out  2  one-cycle completion strobe to the owner port
rsp_err  out  1  qualifies rsp_valid: 1 = NACK after all retries, or timeout
eng_data  out  24  word presented to engine, stable from eng_start to eng_done
eng_start  out  1  one-cycle start pulse to engine
eng_done  in  1  engine completion pulse
eng_ack_err  in  1  valid with eng_done: 1 = slave NACK
busy  out  1  high in every state except IDLE
err_count  out  8  saturating count of rsp_err events

Behaviour:
- Reset (async, any state): state=IDLE, last_grant=1 (so port 0 wins the first tie), all outputs 0, retry/timeout/gap counters 0, err_count=0.
- States: IDLE, ISSUE, WAIT, BACKOFF, RESP, GAP.
- IDLE: if any req_valid, grant one. If only one is valid, grant it. If both are valid, grant ~last_grant.
- Grant is combinational in IDLE: req_ready[g]=1 for exactly that cycle. At the edge: capture req_data_g into eng_data, owner<=g, last_grant<=g, retry<=0, go to ISSUE.
- ISSUE: eng_start=1 for one cycle; timeout counter<=0; go to WAIT.
- WAIT: timeout counter increments each cycle.
  - eng_done with eng_ack_err=0 -> RESP, success.
  - eng_done with eng_ack_err=1 and retry<MAX_RETRY -> retry++, BACKOFF.
  - eng_done with eng_ack_err=1 and retry==MAX_RETRY -> RESP, error.
  - Counter reaches TIMEOUT_CYC without eng_done -> RESP, error.
  - eng_done on the same cycle as the timeout: eng_done wins.
- BACKOFF: wait GAP_CYC cycles, then ISSUE with the same eng_data.
- RESP: rsp_valid[owner]=1 and rsp_err set for one cycle. err_count++ on error, saturating at 255. Go to GAP.
- GAP: GAP_CYC cycles with no eng_start, then IDLE. Minimum engine-start spacing is GAP_CYC+2 cycles.
- eng_done outside WAIT is ignored (late completion after a timeout is dropped).
- Latency for a successful first attempt: req_ready at cycle 0, eng_start at cycle 1, rsp_valid one cycle after eng_done.
- eng_data changes only on a grant edge. rsp_err is 0 whenever rsp_valid==0.
- req_valid deasserting without req_ready is legal and leaves no trace. Requests are never queued internally (single outstanding transfer).
- No starvation: with both ports continuously valid, grants strictly alternate 0,1,0,1…

Test Plan:
- Single port 0 request 0x729803, engine acks after 20 cycles -> req_ready[0] at c0, eng_start at c1 with eng_data=0x729803, rsp_valid[0]=1, rsp_err=0 one cycle after eng_done; busy low after GAP.
- Both ports valid from reset (p0 0x721630, p1 0x72AF16), engine always acks -> grant order p0,p1,p0,p1; eng_data matches owner each time; no overlapping eng_start.
- Port 1 write, engine NACKs 3 times then acks (MAX_RETRY=3) -> 4 eng_start pulses spaced by BACKOFF, single rsp_valid[1] with rsp_err=0; NACK 4 times -> rsp_err=1, err_count=1.
- Engine never returns eng_done (TIMEOUT_CYC=15) -> rsp_valid=1 with rsp_err=1 exactly 16 cycles after eng_start; a late eng_done injected in GAP is ignored; next request serviced normally.
- Assert reset during WAIT -> immediate IDLE, outputs 0, err_count=0; re-issued request from port 0 completes normally. Also force 256 errors -> err_count holds 255.
